instr_fetch_unit: RTL

//  Fetch stage sitting between program_counter and instruction decode of the 16-bit CPU.

---
 rtl/instr_fetch_unit_pkg.sv | 16 +
 rtl/instr_fetch_unit_timeout_ctr.sv | 31 +++
 rtl/instr_fetch_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the 16-bit CPU fetch stage.
package instr_fetch_unit_pkg;

    localparam int CPU_WORD_W = 16;

    localparam logic [CPU_WORD_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_timeout_ctr.sv
// Wait-cycle counter for the fetch stage: cleared on load, counts up on inc,
// flags the last cycle allowed before a memory timeout.
module instr_fetch_unit_timeout_ctr #(
    parameter int TIMEOUT_CYC = 15,
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic inc_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;

    // Count register; load takes priority over increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (load_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (inc_i) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign tc_o = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads the word at PC over a req/valid handshake, holds it for
// decode, strobes the program counter and traps memory hangs.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int WORD_W      = CPU_WORD_W,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              flush,
    input  logic [WORD_W-1:0] pc_in,
    output logic              pc_enable,
    output logic              mem_rd_req,
    output logic [WORD_W-1:0] mem_addr,
    input  logic              mem_rd_valid,
    input  logic [WORD_W-1:0] mem_rd_data,
    output logic [WORD_W-1:0] instr_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fetch_fault
);

    fetch_state_e      state_q;
    logic              mem_rd_req_q;
    logic [WORD_W-1:0] mem_addr_q;
    logic [WORD_W-1:0] instr_out_q;
    logic              instr_valid_q;
    logic              fetch_fault_q;
    logic              discard_q;

    logic              in_wait_s;
    logic              drop_s;
    logic              tc_s;

    assign in_wait_s = (state_q == ST_WAIT);
    assign drop_s    = discard_q | flush;

    instr_fetch_unit_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_ctr (
        .clk    (clk),
        .reset  (reset),
        .load_i (state_q == ST_REQ),
        .inc_i  (in_wait_s & ~mem_rd_valid),
        .tc_o   (tc_s)
    );

    // Fetch FSM with registered handshake and instruction-register outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            mem_rd_req_q  <= 1'b0;
            mem_addr_q    <= {WORD_W{1'b0}};
            instr_out_q   <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            mem_rd_req_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_q      <= ST_REQ;
                        mem_addr_q   <= pc_in;
                        mem_rd_req_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    state_q <= ST_WAIT;
                    // A redirect while the request is on the bus kills its answer.
                    if (flush) begin
                        discard_q <= 1'b1;
                    end else begin
                        discard_q <= discard_q;
                    end
                end
                ST_WAIT: begin
                    if (mem_rd_valid) begin
                        if (drop_s) begin
                            discard_q <= 1'b0;
                            if (run) begin
                                state_q      <= ST_REQ;
                                mem_addr_q   <= pc_in;
                                mem_rd_req_q <= 1'b1;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            instr_out_q   <= mem_rd_data;
                            instr_valid_q <= 1'b1;
                            state_q       <= ST_HOLD;
                        end
                    end else if (tc_s) begin
                        state_q       <= ST_FAULT;
                        fetch_fault_q <= 1'b1;
                        discard_q     <= 1'b0;
                    end else begin
                        state_q <= ST_WAIT;
                        if (flush) begin
                            discard_q <= 1'b1;
                        end else begin
                            discard_q <= discard_q;
                        end
                    end
                end
                ST_HOLD: begin
                    if (flush || instr_ready) begin
                        instr_valid_q <= 1'b0;
                        if (run) begin
                            state_q      <= ST_REQ;
                            mem_addr_q   <= pc_in;
                            mem_rd_req_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        state_q <= ST_HOLD;
                    end
                end
                ST_FAULT: begin
                    state_q <= ST_FAULT;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // PC strobe fires on the accepting edge so the PC advances with the capture.
    always_comb begin
        pc_enable = 1'b0;
        if (!reset && in_wait_s && mem_rd_valid && !drop_s) begin
            pc_enable = 1'b1;
        end else begin
            pc_enable = 1'b0;
        end
    end

    assign mem_rd_req  = mem_rd_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr_out   = instr_out_q;
    assign instr_valid = instr_valid_q;
    assign fetch_fault = fetch_fault_q;

endmodule
